// File: rtl/display_arbiter.sv
`default_nettype none
// display_arbiter: round-robin ownership of the shared 4-digit display with a minimum hold time.
// The owner's value is tracked live and clamped to 0..9999 before it reaches the display driver.
module display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 10_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [13:0] num0,
  input  logic [13:0] num1,
  input  logic [13:0] num2,
  output logic [2:0]  gnt,
  output logic [13:0] number,
  output logic        sat
);

  localparam logic [13:0] MAX_DISPLAY = 14'd9999;
  localparam logic [23:0] HOLD_RELOAD = 24'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t      state;
  logic [1:0]  ptr;         // last winner; equals the current owner while in OWN
  logic [23:0] hold_cnt;
  logic [1:0]  pick;
  logic        pick_valid;
  logic [1:0]  search_idx;
  logic [13:0] owner_val;
  logic [13:0] pick_val;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [13:0] value_of(input logic [1:0] i, input logic [13:0] v0,
                                           input logic [13:0] v1, input logic [13:0] v2);
    case (i)
      2'd0:    return v0;
      2'd1:    return v1;
      default: return v2;
    endcase
  endfunction

  function automatic logic [13:0] clamp(input logic [13:0] v);
    return (v > MAX_DISPLAY) ? MAX_DISPLAY : v;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

  // Search starts just after the last winner, so the owner itself is considered last.
  always_comb begin
    pick       = ptr;
    pick_valid = 1'b0;
    search_idx = ptr;
    for (int k = 0; k < 3; k++) begin
      search_idx = next_idx(search_idx);
      if (!pick_valid && req[search_idx]) begin
        pick       = search_idx;
        pick_valid = 1'b1;
      end
    end
  end

  assign owner_val = value_of(ptr, num0, num1, num2);
  assign pick_val  = value_of(pick, num0, num1, num2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= 3'b000;
      number   <= 14'd0;
      sat      <= 1'b0;
      hold_cnt <= 24'd0;
      ptr      <= 2'd2;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= OWN;
            ptr      <= pick;
            gnt      <= onehot(pick);
            number   <= clamp(pick_val);
            sat      <= (pick_val > MAX_DISPLAY);
            hold_cnt <= HOLD_RELOAD;
          end
        end
        OWN: begin
          if (hold_cnt != 24'd0) begin
            hold_cnt <= hold_cnt - 24'd1;
            number   <= clamp(owner_val);
            sat      <= (owner_val > MAX_DISPLAY);
          end else if (pick_valid) begin
            ptr      <= pick;
            gnt      <= onehot(pick);
            number   <= clamp(pick_val);
            sat      <= (pick_val > MAX_DISPLAY);
            hold_cnt <= HOLD_RELOAD;
          end else begin
            state <= IDLE;
            gnt   <= 3'b000;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 3'b000;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/display_arbiter.md
# display_arbiter

Shares the single 4-digit seven-segment display between three requesters (e.g. counter value, debug value, error code). Grants ownership round-robin with a minimum hold time so each value stays readable. Drives the 14-bit `number` input of the BCD/seven-segment display driver with the owner's value, clamped to the displayable range 0–9999.

## Interface
- `HOLD_CYCLES`, default 10_000_000: minimum grant duration in clk cycles (0.1 s at 100 MHz); legal range 1 to 2^24−1.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `req`  in  3  request per requester; level-sensitive; bit i = requester i.
- `num0`  in  14  value of requester 0 (unsigned).
- `num1`  in  14  value of requester 1 (unsigned).
- `num2`  in  14  value of requester 2 (unsigned).
- `gnt`  out  3  one-hot grant, or all zero; registered.
- `number`  out  14  value to display driver; registered; always ≤ 9999.
- `sat`  out  1  high while the displayed value was clamped; registered.

## Operation
- States: IDLE (no owner), OWN (one owner, hold counter running).
- Reset (`rst_n`=0 at posedge):
  - state = IDLE, `gnt` = 0, `number` = 0, `sat` = 0, hold counter = 0.
  - last-winner pointer = 2, so requester 0 has first priority.
- Round-robin pick: search `req` starting at last-winner+1, modulo 3. The first asserted bit wins, and the pointer becomes that index.
- IDLE:
  - If `req` ≠ 0: pick a winner, set `gnt` one-hot, load the counter with HOLD_CYCLES−1, go to OWN.
  - Else: hold `number`/`sat` at their last values; `gnt` stays 0.
- OWN, every cycle:
  - `number` <= clamp(num[owner]).
  - `sat` <= (num[owner] > 9999).
  - This is live tracking: owner value changes appear on `number` 1 cycle later.
- OWN, counter ≠ 0: decrement. The owner keeps `gnt` even if its `req` drops.
- OWN, counter = 0 (expiry):
  - Another requester asserted: pick it by round-robin. `gnt` moves directly to it, `number` loads its value, and the counter reloads. No idle gap.
  - Only the owner requesting: stay in OWN and reload the counter.
  - No request: go to IDLE, `gnt` = 0, `number`/`sat` frozen at the last owned value.
- Clamp: values 10000–16383 map to 9999 (all four digits show 9). 0–9999 pass unchanged.
- Reset mid-operation: takes effect at the next posedge regardless of state. Outputs return to reset values.

## Timing
- Request to grant: 1 cycle from IDLE. A `req` sampled high at edge k gives `gnt` and `number` valid after edge k.
- Minimum grant: exactly HOLD_CYCLES cycles; `gnt` changes only at the edge following counter = 0.
- HOLD_CYCLES = 1: grant can rotate every cycle.
- `num` input to `number` latency: 1 cycle while owned.
- `gnt`, `number` and `sat` change on the same edge, so `number` is never shown under a stale grant.
- Simultaneous requests: resolved by the round-robin pointer only; there is no fixed priority after reset.
- A requester that drops and re-raises `req` during another's grant waits for the current owner's expiry.
- Counter: 24 bits. Expected RTL: about 150 lines.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles with `req`=3'b111 → `gnt`=0, `number`=0, `sat`=0. After release, `gnt`=3'b001 one cycle later, with `number`=num0.
- **Rotation (HOLD_CYCLES=4, `req`=3'b111, num0=1, num1=22, num2=333):** `gnt` sequence 001, 010, 100, 001, each held exactly 4 cycles with no gap. `number` follows 1, 22, 333, 1.
- **Early drop:** requester 1 alone, owner drops `req` after 1 cycle (HOLD_CYCLES=4) → `gnt`=010 for 4 cycles, then 0. `number` stays at num1's last value, e.g. 4321, indefinitely.
- **Clamp:** owner value 12000 → `number`=9999, `sat`=1. Value changed to 9999 → `number`=9999, `sat`=0. Value changed to 0 → `number`=0.
- **Live tracking and lone owner:** only `req`[2] high, num2 ramps 0..20 one per cycle → `gnt` stays 100 across reloads, and `number` equals num2 delayed 1 cycle.
- **Mid-grant reset:** assert `rst_n`=0 during requester 2's grant → next cycle `gnt`=0, `number`=0. After release with `req`=3'b111, the winner is requester 0.
